// File: rtl/elevator_state_bank.sv
// elevator_state_bank: parametrised state register bank for the elevator
// scheduler with a small IDLE/RUN/DONE run-control FSM on top.
// Optional feature: define ELEV_STEP_COUNT_EN to build the committed-step
// counter with saturation timeout; otherwise step_count/timeout read 0.
module elevator_state_bank #(
   parameter int  NUM_FLOORS = 7,
   parameter int  NUM_CARS   = 2,
   parameter int  CNT_W      = 6,
   parameter int  STEP_W     = 8,
   localparam int FLR_W      = $clog2(NUM_FLOORS)
) (
   input  logic                        clock,
   input  logic                        reset_start_n,
   input  logic                        start,
   input  logic [NUM_FLOORS*CNT_W-1:0] passenger_in,
   input  logic [NUM_CARS*FLR_W-1:0]   init_car,
   input  logic                        step_en,
   input  logic [NUM_FLOORS*CNT_W-1:0] remaining_next,
   input  logic [NUM_CARS*CNT_W-1:0]   boarding_next,
   input  logic [NUM_CARS*FLR_W-1:0]   curr_car_next,
   input  logic [NUM_CARS*2-1:0]       dir_car_next,
   output logic [NUM_FLOORS*CNT_W-1:0] remaining,
   output logic [NUM_CARS*CNT_W-1:0]   boarding,
   output logic [NUM_CARS*FLR_W-1:0]   curr_car,
   output logic [NUM_CARS*2-1:0]       dir_car,
   output logic                        busy,
   output logic                        done,
   output logic                        range_err,
   output logic [STEP_W-1:0]           step_count,
   output logic                        timeout
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [FLR_W-1:0] FLR_MAX = FLR_W'(NUM_FLOORS - 1);

   state_t                        r_state;
   logic [NUM_FLOORS*CNT_W-1:0]   r_remaining;
   logic [NUM_CARS*CNT_W-1:0]     r_boarding;
   logic [NUM_CARS*FLR_W-1:0]     r_curr_car;
   logic [NUM_CARS*2-1:0]         r_dir_car;
   logic                          r_range_err;

   logic [NUM_CARS*FLR_W-1:0]     w_init_flr;
   logic [NUM_CARS*2-1:0]         w_init_dir;
   logic                          w_init_oor;
   logic [NUM_CARS*FLR_W-1:0]     w_nxt_flr;
   logic [NUM_CARS*2-1:0]         w_nxt_dir;
   logic                          w_nxt_oor;
   logic                          w_pin_zero;
   logic                          w_nxt_zero;

`ifdef ELEV_STEP_COUNT_EN
   localparam logic [STEP_W-1:0] STEP_MAX = '1;
   logic [STEP_W-1:0]            r_step_cnt;
   logic                         r_timeout;
`endif

   // Clamp floor indices, derive the initial heading, and sanitise direction codes
   always_comb begin
      w_init_flr = '0;
      w_init_dir = '0;
      w_init_oor = 1'b0;
      w_nxt_flr  = '0;
      w_nxt_dir  = '0;
      w_nxt_oor  = 1'b0;
      for (int c = 0; c < NUM_CARS; c++) begin
         if (32'(init_car[c*FLR_W +: FLR_W]) >= NUM_FLOORS) begin
            w_init_flr[c*FLR_W +: FLR_W] = FLR_MAX;
            w_init_oor = 1'b1;
         end else begin
            w_init_flr[c*FLR_W +: FLR_W] = init_car[c*FLR_W +: FLR_W];
         end
         // Cars in the lower half head up, the rest head down
         w_init_dir[c*2 +: 2] = (32'(init_car[c*FLR_W +: FLR_W]) < NUM_FLOORS/2) ? 2'b10 : 2'b01;
         if (32'(curr_car_next[c*FLR_W +: FLR_W]) >= NUM_FLOORS) begin
            w_nxt_flr[c*FLR_W +: FLR_W] = FLR_MAX;
            w_nxt_oor = 1'b1;
         end else begin
            w_nxt_flr[c*FLR_W +: FLR_W] = curr_car_next[c*FLR_W +: FLR_W];
         end
         // Code 11 has no meaning and is stored as idle
         w_nxt_dir[c*2 +: 2] = (dir_car_next[c*2 +: 2] == 2'b11) ? 2'b00 : dir_car_next[c*2 +: 2];
      end
      w_pin_zero = (passenger_in == '0);
      w_nxt_zero = (remaining_next == '0) && (boarding_next == '0);
   end

   // Run-control FSM and state bank; start has priority over everything else
   always_ff @(posedge clock or negedge reset_start_n) begin
      if (!reset_start_n) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_boarding  <= '0;
         r_curr_car  <= '0;
         r_dir_car   <= '0;
         r_range_err <= 1'b0;
`ifdef ELEV_STEP_COUNT_EN
         r_step_cnt  <= '0;
         r_timeout   <= 1'b0;
`endif
      end else if (start) begin
         r_remaining <= passenger_in;
         r_boarding  <= '0;
         r_curr_car  <= w_init_flr;
         r_dir_car   <= w_init_dir;
         r_range_err <= w_init_oor;
         r_state     <= w_pin_zero ? S_DONE : S_RUN;
`ifdef ELEV_STEP_COUNT_EN
         r_step_cnt  <= '0;
         r_timeout   <= 1'b0;
`endif
      end else if (r_state == S_RUN) begin
`ifdef ELEV_STEP_COUNT_EN
         if (r_timeout) begin
            // Counter saturated on the previous commit: stop the run
            r_state <= S_DONE;
         end else
`endif
         if (step_en) begin
            r_remaining <= remaining_next;
            r_boarding  <= boarding_next;
            r_curr_car  <= w_nxt_flr;
            r_dir_car   <= w_nxt_dir;
            r_range_err <= r_range_err | w_nxt_oor;
            if (w_nxt_zero) r_state <= S_DONE;
`ifdef ELEV_STEP_COUNT_EN
            if (r_step_cnt != STEP_MAX) r_step_cnt <= r_step_cnt + STEP_W'(1);
            if (r_step_cnt == STEP_MAX - STEP_W'(1)) r_timeout <= 1'b1;
`endif
         end
      end
   end

   assign remaining = r_remaining;
   assign boarding  = r_boarding;
   assign curr_car  = r_curr_car;
   assign dir_car   = r_dir_car;
   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_DONE);
   assign range_err = r_range_err;
`ifdef ELEV_STEP_COUNT_EN
   assign step_count = r_step_cnt;
   assign timeout    = r_timeout;
`else
   assign step_count = '0;
   assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_elevator_state_bank.sv
// Testbench for elevator_state_bank: directed scenario plus randomized run
// checked every cycle against a behavioural model of the scheduler state.
module tb_elevator_state_bank;
   localparam int NF     = 7;
   localparam int NC     = 2;
   localparam int CW     = 6;
   localparam int SW     = 2;
   localparam int FW     = $clog2(NF);
   localparam int SMAX   = (1 << SW) - 1;

   logic clock = 1'b0;
   logic reset_start_n = 1'b0;
   logic start = 1'b0;
   logic step_en = 1'b0;
   logic [NF*CW-1:0] passenger_in = '0, remaining_next = '0, remaining;
   logic [NC*FW-1:0] init_car = '0, curr_car_next = '0, curr_car;
   logic [NC*CW-1:0] boarding_next = '0, boarding;
   logic [NC*2-1:0]  dir_car_next = '0, dir_car;
   logic busy, done, range_err, timeout;
   logic [SW-1:0] step_count;

   int total = 0;
   int bad = 0;
   bit chk_en = 0;

   elevator_state_bank #(.NUM_FLOORS(NF), .NUM_CARS(NC), .CNT_W(CW), .STEP_W(SW)) dut (
      .clock(clock), .reset_start_n(reset_start_n), .start(start),
      .passenger_in(passenger_in), .init_car(init_car), .step_en(step_en),
      .remaining_next(remaining_next), .boarding_next(boarding_next),
      .curr_car_next(curr_car_next), .dir_car_next(dir_car_next),
      .remaining(remaining), .boarding(boarding), .curr_car(curr_car), .dir_car(dir_car),
      .busy(busy), .done(done), .range_err(range_err),
      .step_count(step_count), .timeout(timeout));

   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 running, 2 finished
   int m_ph;
   int m_rem [NF];
   int m_brd [NC];
   int m_flr [NC];
   int m_dir [NC];
   bit m_err;
   int m_cnt;
   bit m_to;

   function automatic int flr_of(input logic [NC*FW-1:0] b, input int c);
      return int'(b[c*FW +: FW]);
   endfunction
   function automatic int clampf(input int v);
      return (v >= NF) ? NF - 1 : v;
   endfunction
   function automatic bit any_oor(input logic [NC*FW-1:0] b);
      for (int c = 0; c < NC; c++) if (flr_of(b, c) >= NF) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clock or negedge reset_start_n) begin
      if (!reset_start_n) begin
         m_ph <= 0; m_err <= 0; m_cnt <= 0; m_to <= 0;
         for (int f = 0; f < NF; f++) m_rem[f] <= 0;
         for (int c = 0; c < NC; c++) begin m_brd[c] <= 0; m_flr[c] <= 0; m_dir[c] <= 0; end
      end else if (start) begin
         for (int f = 0; f < NF; f++) m_rem[f] <= int'(passenger_in[f*CW +: CW]);
         for (int c = 0; c < NC; c++) begin
            m_brd[c] <= 0;
            m_flr[c] <= clampf(flr_of(init_car, c));
            m_dir[c] <= (flr_of(init_car, c) < NF/2) ? 2 : 1;
         end
         m_err <= any_oor(init_car);
         m_cnt <= 0; m_to <= 0;
         m_ph  <= (passenger_in == '0) ? 2 : 1;
      end else if (m_ph == 1) begin
`ifdef ELEV_STEP_COUNT_EN
         if (m_to) m_ph <= 2;
         else
`endif
         if (step_en) begin
            for (int f = 0; f < NF; f++) m_rem[f] <= int'(remaining_next[f*CW +: CW]);
            for (int c = 0; c < NC; c++) begin
               m_brd[c] <= int'(boarding_next[c*CW +: CW]);
               m_flr[c] <= clampf(flr_of(curr_car_next, c));
               m_dir[c] <= (dir_car_next[c*2 +: 2] == 2'b11) ? 0 : int'(dir_car_next[c*2 +: 2]);
            end
            m_err <= m_err | any_oor(curr_car_next);
            if (remaining_next == '0 && boarding_next == '0) m_ph <= 2;
`ifdef ELEV_STEP_COUNT_EN
            if (m_cnt < SMAX) m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == SMAX) m_to <= 1;
`endif
         end
      end
   end

   function automatic logic [63:0] e_rem();
      logic [NF*CW-1:0] v = '0;
      for (int f = 0; f < NF; f++) v[f*CW +: CW] = CW'(m_rem[f]);
      return 64'(v);
   endfunction
   function automatic logic [63:0] e_brd();
      logic [NC*CW-1:0] v = '0;
      for (int c = 0; c < NC; c++) v[c*CW +: CW] = CW'(m_brd[c]);
      return 64'(v);
   endfunction
   function automatic logic [63:0] e_flr();
      logic [NC*FW-1:0] v = '0;
      for (int c = 0; c < NC; c++) v[c*FW +: FW] = FW'(m_flr[c]);
      return 64'(v);
   endfunction
   function automatic logic [63:0] e_dir();
      logic [NC*2-1:0] v = '0;
      for (int c = 0; c < NC; c++) v[c*2 +: 2] = 2'(m_dir[c]);
      return 64'(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clock) begin
      if (chk_en) begin
         chk("remaining", 64'(remaining), e_rem());
         chk("boarding",  64'(boarding),  e_brd());
         chk("curr_car",  64'(curr_car),  e_flr());
         chk("dir_car",   64'(dir_car),   e_dir());
         chk("busy",      64'(busy),      64'(m_ph == 1));
         chk("done",      64'(done),      64'(m_ph == 2));
         chk("range_err", 64'(range_err), 64'(m_err));
         chk("step_count",64'(step_count),64'(m_cnt));
         chk("timeout",   64'(timeout),   64'(m_to));
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [NF*CW-1:0] P0  = {6'd4, 6'd1, 6'd0, 6'd0, 6'd2, 6'd0, 6'd3};
   localparam logic [NC*FW-1:0] IC0 = {3'd1, 3'd5};
   localparam logic [NF*CW-1:0] RN1 = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7};
   localparam logic [NC*CW-1:0] BN1 = {6'd9, 6'd8};

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic load(input logic [NF*CW-1:0] p, input logic [NC*FW-1:0] ic);
      start = 1; passenger_in = p; init_car = ic; tick(); start = 0;
   endtask

   task automatic step(input logic [NF*CW-1:0] r, input logic [NC*CW-1:0] b,
                       input logic [NC*FW-1:0] fl, input logic [NC*2-1:0] d);
      step_en = 1; remaining_next = r; boarding_next = b; curr_car_next = fl; dir_car_next = d;
      tick(); step_en = 0;
   endtask

   initial begin
      tick(); tick();
      reset_start_n = 1; chk_en = 1;
      chk("reset remaining", 64'(remaining), 64'd0);
      chk("reset dir", 64'(dir_car), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);

      // Scenario load
      load(P0, IC0);
      chk("load remaining", 64'(remaining), 64'(P0));
      chk("load boarding", 64'(boarding), 64'd0);
      chk("load curr_car", 64'(curr_car), 64'b001_101);
      chk("load dir_car", 64'(dir_car), 64'b10_01);
      chk("load busy", 64'(busy), 64'd1);

      // Hold with step_en low while next buses wiggle
      for (int i = 0; i < 3; i++) begin
         remaining_next = RN1; boarding_next = BN1; curr_car_next = '1; dir_car_next = '1;
         tick();
         chk("hold remaining", 64'(remaining), 64'(P0));
      end

      // Commit, with 11 direction mapped to idle
      step(RN1, BN1, {3'd2, 3'd4}, {2'b11, 2'b10});
      chk("commit remaining", 64'(remaining), 64'(RN1));
      chk("commit curr_car", 64'(curr_car), 64'b010_100);
      chk("commit dir_car", 64'(dir_car), 64'b00_10);

      // Range clamp, sticky
      step(RN1, BN1, {3'd3, 3'd7}, 4'b0101);
      chk("clamp curr_car", 64'(curr_car), 64'b011_110);
      chk("clamp range_err", 64'(range_err), 64'd1);
      step(RN1, BN1, {3'd0, 3'd0}, 4'b0101);
      chk("sticky range_err", 64'(range_err), 64'd1);

      // Start/step collision: reload wins
      start = 1; passenger_in = P0; init_car = IC0;
      step(RN1, BN1, {3'd2, 3'd2}, 4'b1010);
      start = 0;
      chk("abort remaining", 64'(remaining), 64'(P0));
      chk("abort boarding", 64'(boarding), 64'd0);
      chk("abort range_err", 64'(range_err), 64'd0);

      // Three committed non-zero steps: timeout with the counter, still running without
      for (int i = 0; i < 3; i++) step(RN1, BN1, {3'd1, 3'd1}, 4'b1010);
`ifdef ELEV_STEP_COUNT_EN
      chk("sat step_count", 64'(step_count), 64'd3);
      chk("sat timeout", 64'(timeout), 64'd1);
      tick();
      chk("timeout done", 64'(done), 64'd1);
`else
      chk("nocnt busy", 64'(busy), 64'd1);
      chk("nocnt step_count", 64'(step_count), 64'd0);
`endif

      // Completion and post-done immunity
      load(P0, IC0);
      step('0, '0, {3'd4, 3'd4}, 4'b0000);
      chk("complete done", 64'(done), 64'd1);
      chk("complete busy", 64'(busy), 64'd0);
      step(RN1, BN1, {3'd2, 3'd2}, 4'b1010);
      chk("done holds remaining", 64'(remaining), 64'd0);
      chk("done holds done", 64'(done), 64'd1);

      // Empty scenario goes straight to done; out-of-range init clamps
      load('0, {3'd0, 3'd7});
      chk("empty done", 64'(done), 64'd1);
      chk("init clamp curr_car", 64'(curr_car), 64'b000_110);
      chk("init clamp range_err", 64'(range_err), 64'd1);

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r == 0) begin
            reset_start_n = 0; tick(); reset_start_n = 1;
            continue;
         end
         start = (r < 6);
         step_en = 1'($urandom);
         for (int f = 0; f < NF; f++) passenger_in[f*CW +: CW] = CW'($urandom);
         if ($urandom_range(0, 3) == 0) passenger_in = '0;
         for (int c = 0; c < NC; c++) begin
            init_car[c*FW +: FW]      = FW'($urandom_range(0, 7));
            curr_car_next[c*FW +: FW] = FW'($urandom_range(0, 7));
            dir_car_next[c*2 +: 2]    = 2'($urandom);
            boarding_next[c*CW +: CW] = CW'($urandom);
         end
         for (int f = 0; f < NF; f++) remaining_next[f*CW +: CW] = CW'($urandom);
         if ($urandom_range(0, 5) == 0) begin remaining_next = '0; boarding_next = '0; end
         tick();
      end
      start = 0; step_en = 0;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
